// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder. A search buffer and a look-ahead window track the
// decoder's window cycle for cycle. Each code is held for code_len+1 cycles,
// so the decoder can consume it without a handshake.
module lz77_encoder #(
    parameter int unsigned SB_DEPTH = 9,
    parameter int unsigned LA_DEPTH = 8,
    parameter logic [7:0]  END_CHAR = 8'h24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  char_in,
    input  logic                        char_valid,
    output logic                        char_ready,
    output logic                        encode,
    output logic [$clog2(SB_DEPTH)-1:0] code_pos,
    output logic [$clog2(LA_DEPTH)-1:0] code_len,
    output logic [7:0]                  chardata,
    output logic                        finish
);
    localparam int unsigned POS_W   = $clog2(SB_DEPTH);
    localparam int unsigned LEN_W   = $clog2(LA_DEPTH);
    localparam int unsigned CNT_W   = $clog2(LA_DEPTH + 1);
    localparam int unsigned MAX_LEN = LA_DEPTH - 1;

    typedef enum logic [1:0] {ST_FILL, ST_SEARCH, ST_EMIT, ST_DONE} state_t;

    state_t             state, state_nxt;
    logic [7:0]         sb [SB_DEPTH];
    logic [7:0]         la [LA_DEPTH];
    logic [CNT_W-1:0]   la_cnt, la_cnt_nxt, lim;
    logic               end_seen, end_seen_nxt;
    logic [POS_W-1:0]   cand, best_pos, sel_pos;
    logic [LEN_W-1:0]   best_len, emit_cnt, cand_len, sel_len, wr_idx;
    logic               xfer, shift, last_emit, fill_exit, fill_exit_nxt;
    logic               run, take;
    logic [7:0]         ref_ch;
    logic               char_ready_d, encode_d, finish_d;

    // Window occupancy bookkeeping for the current cycle
    always_comb begin
        xfer       = char_valid & char_ready;
        shift      = (state == ST_EMIT);
        last_emit  = shift && (emit_cnt == code_len);
        la_cnt_nxt = la_cnt;
        if (xfer && !shift) begin
            la_cnt_nxt = la_cnt + CNT_W'(1);
        end else if (shift && !xfer) begin
            la_cnt_nxt = la_cnt - CNT_W'(1);
        end
        end_seen_nxt  = end_seen | (xfer && (char_in == END_CHAR));
        wr_idx        = shift ? LEN_W'(la_cnt - CNT_W'(1)) : LEN_W'(la_cnt);
        fill_exit     = (la_cnt == CNT_W'(LA_DEPTH)) || (end_seen && (la_cnt != '0));
        fill_exit_nxt = (la_cnt_nxt == CNT_W'(LA_DEPTH)) || (end_seen_nxt && (la_cnt_nxt != '0));
    end

    // Match length at candidate distance cand+1; one literal is always left over
    always_comb begin
        lim = (la_cnt == '0) ? '0 : la_cnt - CNT_W'(1);
        if (lim > CNT_W'(MAX_LEN)) begin
            lim = CNT_W'(MAX_LEN);
        end
        cand_len = '0;
        run      = 1'b1;
        ref_ch   = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (i <= int'(cand)) begin
                ref_ch = sb[POS_W'(int'(cand) - i)];
            end else begin
                ref_ch = la[LEN_W'(i - int'(cand) - 1)];
            end
            if (run && (CNT_W'(i) < lim) && (la[LEN_W'(i)] == ref_ch)) begin
                cand_len = cand_len + LEN_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        take    = (cand == '0) || (cand_len > best_len);
        sel_len = take ? cand_len : best_len;
        sel_pos = take ? cand : best_pos;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL:   if (fill_exit) state_nxt = ST_SEARCH;
            ST_SEARCH: if (cand == POS_W'(SB_DEPTH - 1)) state_nxt = ST_EMIT;
            ST_EMIT: begin
                if (last_emit) begin
                    if (chardata == END_CHAR) begin
                        state_nxt = ST_DONE;
                    end else if (fill_exit_nxt) begin
                        state_nxt = ST_SEARCH;
                    end else begin
                        state_nxt = ST_FILL;
                    end
                end
            end
            ST_DONE:   state_nxt = ST_DONE;
            default:   state_nxt = ST_FILL;
        endcase
    end

    // Next values of the registered control outputs
    always_comb begin
        char_ready_d = ((state_nxt == ST_FILL) || (state_nxt == ST_EMIT)) &&
                       (la_cnt_nxt < CNT_W'(LA_DEPTH)) && !end_seen_nxt;
        encode_d     = (state_nxt == ST_EMIT);
        finish_d     = last_emit && (chardata == END_CHAR);
    end

    // Window shifting, candidate sweep and code registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(SB_DEPTH); k++) sb[k] <= '0;
            for (int k = 0; k < int'(LA_DEPTH); k++) la[k] <= '0;
            la_cnt     <= '0;
            end_seen   <= 1'b0;
            cand       <= '0;
            best_pos   <= '0;
            best_len   <= '0;
            emit_cnt   <= '0;
            char_ready <= 1'b0;
            encode     <= 1'b0;
            finish     <= 1'b0;
            code_pos   <= '0;
            code_len   <= '0;
            chardata   <= '0;
        end else begin
            la_cnt     <= la_cnt_nxt;
            end_seen   <= end_seen_nxt;
            char_ready <= char_ready_d;
            encode     <= encode_d;
            finish     <= finish_d;
            if (shift) begin
                sb[0] <= la[0];
                for (int k = 1; k < int'(SB_DEPTH); k++) sb[k] <= sb[k-1];
                for (int k = 0; k < int'(LA_DEPTH) - 1; k++) la[k] <= la[k+1];
                emit_cnt <= emit_cnt + LEN_W'(1);
            end
            if (xfer) begin
                la[wr_idx] <= char_in;
            end
            if (state == ST_SEARCH) begin
                best_len <= sel_len;
                best_pos <= sel_pos;
                if (cand == POS_W'(SB_DEPTH - 1)) begin
                    cand     <= '0;
                    code_len <= sel_len;
                    code_pos <= (sel_len == '0) ? '0 : sel_pos;
                    chardata <= la[sel_len];
                    emit_cnt <= '0;
                end else begin
                    cand <= cand + POS_W'(1);
                end
            end
        end
    end
endmodule
